// File: rtl/multicycle_main_fsm_pkg.sv
// Shared types and encodings for the multi-cycle RV32I main control FSM.
package multicycle_main_fsm_pkg;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEMADR,
        MEMREAD,
        MEMWB,
        MEMWRITE,
        EXECUTER,
        EXECUTEI,
        ALUWB,
        JAL,
        BEQ,
        ILLEGAL
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/multicycle_main_fsm_if.sv
// Control bus between the main FSM (master) and the shared datapath/memory (slave).
interface multicycle_main_fsm_if #(
    parameter int CNT_W = 32
);
    logic [6:0]       Op;
    logic             Zero;
    logic             MemReady;
    logic             MemReq;
    logic             MemWrite;
    logic             AdrSrc;
    logic             IRWrite;
    logic             PCWrite;
    logic             RegWrite;
    logic [1:0]       ALUSrcA;
    logic [1:0]       ALUSrcB;
    logic [1:0]       ALUOp;
    logic [1:0]       ResultSrc;
    logic [1:0]       ImmSrc;
    logic             InstrRetired;
    logic [CNT_W-1:0] RetireCount;
    logic             Halt;

    // Memory handshake: MemReq is held high (with address/strobe stable) every
    // cycle of an access; the access completes on the cycle MemReady is also high.
    modport master (
        input  Op, Zero, MemReady,
        output MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
               ALUSrcA, ALUSrcB, ALUOp, ResultSrc, ImmSrc,
               InstrRetired, RetireCount, Halt
    );

    modport slave (
        output Op, Zero, MemReady,
        input  MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
               ALUSrcA, ALUSrcB, ALUOp, ResultSrc, ImmSrc,
               InstrRetired, RetireCount, Halt
    );
endinterface

// File: rtl/multicycle_main_fsm_instr_decoder.sv
// Combinational opcode to immediate-format selector.
module multicycle_main_fsm_instr_decoder
    import multicycle_main_fsm_pkg::*;
(
    input  logic [6:0] i_op,
    output logic [1:0] o_imm_src
);
    always_comb begin
        o_imm_src = IMM_I;
        case (i_op)
            OP_LW, OP_I: o_imm_src = IMM_I;
            OP_SW:       o_imm_src = IMM_S;
            OP_BEQ:      o_imm_src = IMM_B;
            OP_JAL:      o_imm_src = IMM_J;
            default:     o_imm_src = IMM_I;
        endcase
    end
endmodule

// File: rtl/multicycle_main_fsm.sv
// Main control FSM of the multi-cycle RV32I core: sequences fetch/decode/execute,
// stalls on memory, halts on illegal opcodes and counts retired instructions.
module multicycle_main_fsm
    import multicycle_main_fsm_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    multicycle_main_fsm_if.master  bus,
    output state_t                 o_dbg_state
);
    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_count;

    logic       w_mem_req, w_mem_write, w_adr_src, w_ir_write;
    logic       w_pc_update, w_branch, w_reg_write, w_retire, w_halt;
    logic [1:0] w_src_a, w_src_b, w_alu_op, w_res_src, w_imm_src;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= FETCH;
            r_count <= '0;
        end else begin
            r_state <= w_next;
            if (w_retire) r_count <= r_count + CNT_W'(1);
        end
    end

    always_comb begin
        w_next      = r_state;
        w_mem_req   = 1'b0;
        w_mem_write = 1'b0;
        w_adr_src   = 1'b0;
        w_ir_write  = 1'b0;
        w_pc_update = 1'b0;
        w_branch    = 1'b0;
        w_reg_write = 1'b0;
        w_retire    = 1'b0;
        w_halt      = 1'b0;
        w_src_a     = SRCA_PC;
        w_src_b     = SRCB_RS2;
        w_alu_op    = ALUOP_ADD;
        w_res_src   = RES_ALUOUT;
        case (r_state)
            FETCH: begin
                w_mem_req   = 1'b1;
                w_src_b     = SRCB_FOUR;
                w_res_src   = RES_ALURESULT;
                w_ir_write  = bus.MemReady;
                w_pc_update = bus.MemReady;
                if (bus.MemReady) w_next = DECODE;
            end
            DECODE: begin
                // Branch target is precomputed here so BEQ only needs the compare.
                w_src_a = SRCA_OLDPC;
                w_src_b = SRCB_IMM;
                case (bus.Op)
                    OP_LW, OP_SW: w_next = MEMADR;
                    OP_R:         w_next = EXECUTER;
                    OP_I:         w_next = EXECUTEI;
                    OP_JAL:       w_next = JAL;
                    OP_BEQ:       w_next = BEQ;
                    default:      w_next = ILLEGAL;
                endcase
            end
            MEMADR: begin
                w_src_a = SRCA_RS1;
                w_src_b = SRCB_IMM;
                w_next  = (bus.Op == OP_LW) ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                w_mem_req = 1'b1;
                w_adr_src = 1'b1;
                if (bus.MemReady) w_next = MEMWB;
            end
            MEMWB: begin
                w_res_src   = RES_DATA;
                w_reg_write = 1'b1;
                w_retire    = 1'b1;
                w_next      = FETCH;
            end
            MEMWRITE: begin
                w_mem_req   = 1'b1;
                w_mem_write = 1'b1;
                w_adr_src   = 1'b1;
                if (bus.MemReady) begin
                    w_retire = 1'b1;
                    w_next   = FETCH;
                end
            end
            EXECUTER: begin
                w_src_a  = SRCA_RS1;
                w_src_b  = SRCB_RS2;
                w_alu_op = ALUOP_FUNCT;
                w_next   = ALUWB;
            end
            EXECUTEI: begin
                w_src_a  = SRCA_RS1;
                w_src_b  = SRCB_IMM;
                w_alu_op = ALUOP_FUNCT;
                w_next   = ALUWB;
            end
            JAL: begin
                w_src_a     = SRCA_OLDPC;
                w_src_b     = SRCB_FOUR;
                w_pc_update = 1'b1;
                w_next      = ALUWB;
            end
            ALUWB: begin
                w_reg_write = 1'b1;
                w_retire    = 1'b1;
                w_next      = FETCH;
            end
            BEQ: begin
                w_src_a  = SRCA_RS1;
                w_src_b  = SRCB_RS2;
                w_alu_op = ALUOP_SUB;
                w_branch = 1'b1;
                w_retire = 1'b1;
                w_next   = FETCH;
            end
            ILLEGAL: w_halt = 1'b1;
            default: w_next = FETCH;
        endcase
    end

    multicycle_main_fsm_instr_decoder u_instr_decoder (
        .i_op      (bus.Op),
        .o_imm_src (w_imm_src)
    );

    // Side-effecting strobes are killed combinationally while reset is held.
    assign bus.MemReq       = rst_n & w_mem_req;
    assign bus.MemWrite     = rst_n & w_mem_write;
    assign bus.IRWrite      = rst_n & w_ir_write;
    assign bus.PCWrite      = rst_n & (w_pc_update | (w_branch & bus.Zero));
    assign bus.RegWrite     = rst_n & w_reg_write;
    assign bus.InstrRetired = rst_n & w_retire;
    assign bus.AdrSrc       = w_adr_src;
    assign bus.ALUSrcA      = w_src_a;
    assign bus.ALUSrcB      = w_src_b;
    assign bus.ALUOp        = w_alu_op;
    assign bus.ResultSrc    = w_res_src;
    assign bus.ImmSrc       = w_imm_src;
    assign bus.RetireCount  = r_count;
    assign bus.Halt         = w_halt;
    assign o_dbg_state      = r_state;
endmodule
